// File: rtl/clksel_sequencer_if.sv
// CPU-side and clock-switch-side signals of the PHI2 clock-select sequencer.
// The slave view belongs to the sequencer; the master view drives it.
interface clksel_sequencer_if;
    // CPU access decode inputs and the divider write port
    logic       cpu_valid;
    logic [7:0] cpu_page;
    logic       force_ls;
    logic       div_wr;
    logic [1:0] div_wdata;
    // Switch feedback (asynchronous) and the registered switch controls
    logic       hsclk_selected;
    logic       lsclk_selected;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       cpu_stall;
    logic       sw_busy;
    logic       sw_timeout;

    modport slave (
        input  cpu_valid, cpu_page, force_ls, div_wr, div_wdata,
        input  hsclk_selected, lsclk_selected,
        output hsclk_sel, cpuclk_div_sel, cpu_stall, sw_busy, sw_timeout
    );

    modport master (
        output cpu_valid, cpu_page, force_ls, div_wr, div_wdata,
        output hsclk_selected, lsclk_selected,
        input  hsclk_sel, cpuclk_div_sel, cpu_stall, sw_busy, sw_timeout
    );
endinterface

// File: rtl/clksel_sequencer.sv
// Decides when the CPU clock moves between the fast clock and PHI2, stalling the CPU mid-switch.
// Optional CLKSEL_HOLDOFF_EN adds a minimum LS dwell before returning to the fast clock.
module clksel_sequencer #(
    parameter logic [7:0] SLOW_PAGE_LO = 8'hFC,
    parameter logic [7:0] SLOW_PAGE_HI = 8'hFE,
    parameter logic [1:0] DIV_RESET    = 2'b00,
    parameter logic [7:0] TMO_CYCLES   = 8'd255
`ifdef CLKSEL_HOLDOFF_EN
    ,
    parameter logic [3:0] LS_DWELL     = 4'd15
`endif
) (
    input  logic                     i_hsclk_in,
    input  logic                     i_rst,
    clksel_sequencer_if.slave        io_bus,
    output logic [1:0]               o_state
);

    typedef enum logic [1:0] {
        ST_LS    = 2'd0,
        ST_TO_HS = 2'd1,
        ST_HS    = 2'd2,
        ST_TO_LS = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_hsclk_sel;
    logic       r_cpu_stall;
    logic       r_sw_busy;
    logic       r_sw_timeout;
    logic [7:0] r_tmo_cnt;
    logic [1:0] r_div_sel;
    logic [1:0] r_div_pend;
    logic       r_div_pend_vld;
    logic       r_hs_meta;
    logic       r_hs_s;
    logic       r_ls_meta;
    logic       r_ls_s;

    logic       w_in_slow_page;
    logic       w_slow_req;
    logic       w_fast_req;
    logic       w_ls_done;
    logic       w_hs_done;
    logic       w_dwell_done;
    logic [7:0] w_tmo_next;

    // Feedback from the switch lives in other clock domains
    always_ff @(posedge i_hsclk_in) begin
        if (i_rst) begin
            r_hs_meta <= 1'b0;
            r_hs_s    <= 1'b0;
            r_ls_meta <= 1'b0;
            r_ls_s    <= 1'b0;
        end else begin
            r_hs_meta <= io_bus.hsclk_selected;
            r_hs_s    <= r_hs_meta;
            r_ls_meta <= io_bus.lsclk_selected;
            r_ls_s    <= r_ls_meta;
        end
    end

    assign w_in_slow_page = (io_bus.cpu_page >= SLOW_PAGE_LO) && (io_bus.cpu_page <= SLOW_PAGE_HI);
    assign w_slow_req     = io_bus.cpu_valid & (io_bus.force_ls | w_in_slow_page);
    assign w_fast_req     = io_bus.cpu_valid & ~w_slow_req;
    assign w_ls_done      = r_ls_s & ~r_hs_s;
    assign w_hs_done      = r_hs_s & ~r_ls_s;
    assign w_tmo_next     = r_tmo_cnt + 8'd1;

`ifdef CLKSEL_HOLDOFF_EN
    logic [3:0] r_dwell;

    // Held at LS_DWELL outside LS so it is full on the entry edge
    always_ff @(posedge i_hsclk_in) begin
        if (i_rst) begin
            r_dwell <= LS_DWELL;
        end else if (r_state != ST_LS) begin
            r_dwell <= LS_DWELL;
        end else if (r_dwell != 4'd0) begin
            r_dwell <= r_dwell - 4'd1;
        end
    end

    assign w_dwell_done = (r_dwell == 4'd0);
`else
    assign w_dwell_done = 1'b1;
`endif

    always_ff @(posedge i_hsclk_in) begin
        if (i_rst) begin
            r_state      <= ST_LS;
            r_hsclk_sel  <= 1'b0;
            r_cpu_stall  <= 1'b0;
            r_sw_busy    <= 1'b0;
            r_sw_timeout <= 1'b0;
            r_tmo_cnt    <= 8'd0;
        end else begin
            case (r_state)
                ST_HS: begin
                    if (w_slow_req) begin
                        r_state     <= ST_TO_LS;
                        r_hsclk_sel <= 1'b0;
                        r_cpu_stall <= 1'b1;
                        r_sw_busy   <= 1'b1;
                        r_tmo_cnt   <= 8'd0;
                    end
                end
                ST_TO_LS: begin
                    if (w_ls_done) begin
                        r_state     <= ST_LS;
                        r_cpu_stall <= 1'b0;
                        r_sw_busy   <= 1'b0;
                    end else if (r_tmo_cnt != TMO_CYCLES) begin
                        r_tmo_cnt <= w_tmo_next;
                        if (w_tmo_next == TMO_CYCLES) begin
                            r_sw_timeout <= 1'b1;
                        end
                    end
                end
                ST_LS: begin
                    if (w_fast_req && w_dwell_done) begin
                        r_state     <= ST_TO_HS;
                        r_hsclk_sel <= 1'b1;
                        r_cpu_stall <= 1'b1;
                        r_sw_busy   <= 1'b1;
                        r_tmo_cnt   <= 8'd0;
                    end
                end
                ST_TO_HS: begin
                    if (w_hs_done) begin
                        r_state     <= ST_HS;
                        r_cpu_stall <= 1'b0;
                        r_sw_busy   <= 1'b0;
                    end else if (r_tmo_cnt != TMO_CYCLES) begin
                        r_tmo_cnt <= w_tmo_next;
                        if (w_tmo_next == TMO_CYCLES) begin
                            r_sw_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_LS;
                end
            endcase
        end
    end

    // The divider only moves while PHI2 is the selected clock; a same-cycle write re-arms pending
    always_ff @(posedge i_hsclk_in) begin
        if (i_rst) begin
            r_div_sel      <= DIV_RESET;
            r_div_pend     <= 2'b00;
            r_div_pend_vld <= 1'b0;
        end else begin
            if ((r_state == ST_LS) && r_div_pend_vld) begin
                r_div_sel      <= r_div_pend;
                r_div_pend_vld <= 1'b0;
            end
            if (io_bus.div_wr) begin
                r_div_pend     <= io_bus.div_wdata;
                r_div_pend_vld <= 1'b1;
            end
        end
    end

    assign io_bus.hsclk_sel      = r_hsclk_sel;
    assign io_bus.cpuclk_div_sel = r_div_sel;
    assign io_bus.cpu_stall      = r_cpu_stall;
    assign io_bus.sw_busy        = r_sw_busy;
    assign io_bus.sw_timeout     = r_sw_timeout;
    assign o_state               = r_state;

endmodule

// File: tb/tb_clksel_sequencer.sv
// Directed bench for clksel_sequencer: a behavioural model checked every cycle plus literal pins.
// Honours CLKSEL_HOLDOFF_EN when the design is built with it.
module tb_clksel_sequencer;

    localparam int M_LS    = 0;
    localparam int M_TO_HS = 1;
    localparam int M_HS    = 2;
    localparam int M_TO_LS = 3;
    localparam logic [1:0] DBG_LS = 2'd0;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    clksel_sequencer_if bus();

    clksel_sequencer dut (
        .i_hsclk_in (clk),
        .i_rst      (rst),
        .io_bus     (bus),
        .o_state    (dbg_state)
    );

    // Model of the sequencer's observable behaviour
    int         m_mode;
    int         m_sw_edges;
    int         m_ls_age;
    bit         m_timeout;
    logic [1:0] m_div;
    logic [1:0] m_pend;
    bit         m_pend_v;
    bit         m_ready = 1'b0;
    bit         hs_q[$];
    bit         ls_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_blk
        bit seen_hs;
        bit seen_ls;
        bit slow;
        bit fast;
        bit dwell_ok;
        if (rst) begin
            m_ready    = 1'b1;
            m_mode     = M_LS;
            m_sw_edges = 0;
            m_ls_age   = 0;
            m_timeout  = 1'b0;
            m_div      = 2'b00;
            m_pend_v   = 1'b0;
            hs_q.delete();
            ls_q.delete();
        end else if (m_ready) begin
            // feedback becomes visible two edges after it is first sampled
            seen_hs = (hs_q.size() == 2) ? hs_q[0] : 1'b0;
            seen_ls = (ls_q.size() == 2) ? ls_q[0] : 1'b0;
            hs_q.push_back(bus.hsclk_selected);
            ls_q.push_back(bus.lsclk_selected);
            if (hs_q.size() > 2) void'(hs_q.pop_front());
            if (ls_q.size() > 2) void'(ls_q.pop_front());

            if (m_mode == M_LS && m_pend_v) begin
                m_div    = m_pend;
                m_pend_v = 1'b0;
            end
            if (bus.div_wr) begin
                m_pend   = bus.div_wdata;
                m_pend_v = 1'b1;
            end

            slow = bus.cpu_valid && (bus.force_ls || (bus.cpu_page inside {[8'hFC:8'hFE]}));
            fast = bus.cpu_valid && !slow;
`ifdef CLKSEL_HOLDOFF_EN
            dwell_ok = (m_ls_age >= 15);
`else
            dwell_ok = 1'b1;
`endif
            if (m_mode == M_HS) begin
                if (slow) begin
                    m_mode     = M_TO_LS;
                    m_sw_edges = 0;
                end
            end else if (m_mode == M_LS) begin
                if (fast && dwell_ok) begin
                    m_mode     = M_TO_HS;
                    m_sw_edges = 0;
                end else begin
                    m_ls_age++;
                end
            end else if (m_mode == M_TO_LS && seen_ls && !seen_hs) begin
                m_mode   = M_LS;
                m_ls_age = 0;
            end else if (m_mode == M_TO_HS && seen_hs && !seen_ls) begin
                m_mode = M_HS;
            end else begin
                m_sw_edges++;
                if (m_sw_edges >= 255) m_timeout = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("hsclk_sel",  8'(bus.hsclk_sel),  8'(m_mode == M_HS || m_mode == M_TO_HS));
            chk("cpu_stall",  8'(bus.cpu_stall),  8'(m_mode == M_TO_HS || m_mode == M_TO_LS));
            chk("sw_busy",    8'(bus.sw_busy),    8'(m_mode == M_TO_HS || m_mode == M_TO_LS));
            chk("sw_timeout", 8'(bus.sw_timeout), 8'(m_timeout));
            chk("div_sel",    8'(bus.cpuclk_div_sel), 8'(m_div));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic request(input logic [7:0] page);
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_page  = page;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
    endtask

    task automatic set_fb(input bit to_hs);
        bus.hsclk_selected = to_hs;
        bus.lsclk_selected = !to_hs;
    endtask

    task automatic wait_settle(input string name);
        int n;
        n = 0;
        while (bus.cpu_stall && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 8'(bus.cpu_stall), 8'd0);
    endtask

    task automatic goto_hs();
        idle(20);
        request(8'h40);
        set_fb(1'b1);
        wait_settle("settle_hs");
    endtask

    task automatic goto_ls(input logic [7:0] page);
        request(page);
        set_fb(1'b0);
        wait_settle("settle_ls");
    endtask

    task automatic write_div(input logic [1:0] v);
        @(negedge clk);
        bus.div_wr    = 1'b1;
        bus.div_wdata = v;
        @(negedge clk);
        bus.div_wr    = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.cpu_valid = 1'b0;
        bus.cpu_page  = 8'h00;
        bus.force_ls  = 1'b0;
        bus.div_wr    = 1'b0;
        bus.div_wdata = 2'b00;
        set_fb(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hsclk_sel", 8'(bus.hsclk_sel), 8'd0);
        chk("rst_div",       8'(bus.cpuclk_div_sel), 8'd0);
        chk("rst_stall",     8'(bus.cpu_stall), 8'd0);
        chk("rst_busy",      8'(bus.sw_busy), 8'd0);
        chk("rst_timeout",   8'(bus.sw_timeout), 8'd0);
        chk("rst_state",     8'(dbg_state), 8'(DBG_LS));

        // LS -> HS with literal stall timing through the synchronisers
        idle(20);
        request(8'h40);
        chk("lit_hs_req_sel",   8'(bus.hsclk_sel), 8'd1);
        chk("lit_hs_req_stall", 8'(bus.cpu_stall), 8'd1);
        set_fb(1'b1);
        @(negedge clk);
        chk("lit_sync_stall1", 8'(bus.cpu_stall), 8'd1);
        @(negedge clk);
        chk("lit_sync_stall2", 8'(bus.cpu_stall), 8'd1);
        @(negedge clk);
        chk("lit_sync_stall3", 8'(bus.cpu_stall), 8'd0);
        chk("lit_in_hs_sel",   8'(bus.hsclk_sel), 8'd1);

        // Divider write in HS stays pending; FF and invalid FD do not switch
        write_div(2'b11);
        idle(2);
        chk("lit_div_held_hs", 8'(bus.cpuclk_div_sel), 8'd0);
        request(8'hFF);
        chk("lit_ff_no_switch", 8'(bus.hsclk_sel), 8'd1);
        @(negedge clk);
        bus.cpu_page = 8'hFD;
        @(negedge clk);
        chk("lit_invalid_no_switch", 8'(bus.hsclk_sel), 8'd1);
        request(8'hFD);
        chk("lit_fd_sel",   8'(bus.hsclk_sel), 8'd0);
        chk("lit_fd_stall", 8'(bus.cpu_stall), 8'd1);
        idle(3);
        chk("lit_div_held_to_ls", 8'(bus.cpuclk_div_sel), 8'd0);
        set_fb(1'b0);
        idle(3);
        chk("lit_ls_entry_stall", 8'(bus.cpu_stall), 8'd0);
        chk("lit_div_not_yet",    8'(bus.cpuclk_div_sel), 8'd0);
        @(negedge clk);
        chk("lit_div_applied",    8'(bus.cpuclk_div_sel), 8'd3);

        // Back-to-back divider writes in LS
        @(negedge clk);
        bus.div_wr    = 1'b1;
        bus.div_wdata = 2'b01;
        @(negedge clk);
        bus.div_wdata = 2'b10;
        @(negedge clk);
        bus.div_wr    = 1'b0;
        idle(2);
        chk("lit_div_b2b", 8'(bus.cpuclk_div_sel), 8'd2);

        // Page range edges and force_ls
        goto_hs();
        goto_ls(8'hFC);
        chk("lit_fc_ls", 8'(bus.hsclk_sel), 8'd0);
        goto_hs();
        goto_ls(8'hFE);
        chk("lit_fe_ls", 8'(bus.hsclk_sel), 8'd0);
        goto_hs();
        bus.force_ls = 1'b1;
        goto_ls(8'h40);
        bus.force_ls = 1'b0;
        chk("lit_force_ls", 8'(bus.hsclk_sel), 8'd0);

        // Timeout: feedback never arrives
        goto_hs();
        request(8'hFD);
        idle(254);
        chk("lit_tmo_254", 8'(bus.sw_timeout), 8'd0);
        @(negedge clk);
        chk("lit_tmo_255", 8'(bus.sw_timeout), 8'd1);
        idle(45);
        chk("lit_tmo_stall", 8'(bus.cpu_stall), 8'd1);
        set_fb(1'b0);
        wait_settle("settle_after_tmo");
        chk("lit_tmo_sticky", 8'(bus.sw_timeout), 8'd1);

        // Fast request shortly after LS entry
        goto_hs();
        request(8'hFD);
        set_fb(1'b0);
        idle(3);
        idle(2);
        bus.cpu_valid = 1'b1;
        bus.cpu_page  = 8'h40;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
`ifdef CLKSEL_HOLDOFF_EN
        chk("lit_dwell_ignored", 8'(bus.hsclk_sel), 8'd0);
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        idle(11);
        chk("lit_dwell_15", 8'(bus.hsclk_sel), 8'd0);
        @(negedge clk);
        chk("lit_dwell_16", 8'(bus.hsclk_sel), 8'd1);
        bus.cpu_valid = 1'b0;
`else
        chk("lit_no_dwell", 8'(bus.hsclk_sel), 8'd1);
`endif
        set_fb(1'b1);
        wait_settle("settle_after_dwell");

        // Reset in the middle of a switchover
        goto_ls(8'hFD);
        idle(20);
        request(8'h40);
        chk("lit_mid_sel", 8'(bus.hsclk_sel), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("lit_mid_rst_sel",   8'(bus.hsclk_sel), 8'd0);
        chk("lit_mid_rst_stall", 8'(bus.cpu_stall), 8'd0);
        chk("lit_mid_rst_tmo",   8'(bus.sw_timeout), 8'd0);
        chk("lit_mid_rst_div",   8'(bus.cpuclk_div_sel), 8'd0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
